// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the MEM/WB stage, the long-latency unit and the register file write port.
// The master side is the pipeline/long-latency source; the slave side is the arbiter.
interface wb_port_arbiter_if #(
   parameter int XLEN = 64,
   parameter int REGW = 5
);
   logic            wb_regwrite;
   logic            wb_memtoreg;
   logic [XLEN-1:0] wb_readdata;
   logic [XLEN-1:0] wb_alu_result;
   logic [REGW-1:0] wb_rd;
   logic            lu_valid;
   logic            lu_ready;
   logic [REGW-1:0] lu_rd;
   logic [XLEN-1:0] lu_data;
   logic            rf_we;
   logic [REGW-1:0] rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic            stall;

   modport master (
      output wb_regwrite, wb_memtoreg, wb_readdata, wb_alu_result, wb_rd,
      output lu_valid, lu_rd, lu_data,
      input  lu_ready, rf_we, rf_waddr, rf_wdata, stall
   );

   modport slave (
      input  wb_regwrite, wb_memtoreg, wb_readdata, wb_alu_result, wb_rd,
      input  lu_valid, lu_rd, lu_data,
      output lu_ready, rf_we, rf_waddr, rf_wdata, stall
   );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between MEM/WB writeback and buffered long-latency results,
// forcing a one-cycle pipeline stall when the FIFO head has waited STARVE_MAX cycles.
module wb_port_arbiter #(
   parameter int XLEN       = 64,
   parameter int REGW       = 5,
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   wb_port_arbiter_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   typedef struct packed {
      logic [REGW-1:0] rd;
      logic [XLEN-1:0] data;
   } entry_t;

   entry_t          r_mem [DEPTH];
   logic [PW-1:0]   r_wptr, r_rptr;
   logic [CW-1:0]   r_count, w_count_next;
   logic [SW-1:0]   r_starve, w_starve_next;
   logic            r_stall, w_stall_next;
   logic            w_empty, w_full, w_wb_req, w_deq, w_enq;

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == FULL_CNT);
   assign w_wb_req = bus.wb_regwrite & (bus.wb_rd != '0) & ~r_stall;
   assign w_deq    = ~w_wb_req & ~w_empty;
   // rd==0 results complete the handshake but never occupy a slot.
   assign w_enq    = bus.lu_valid & ~w_full & (bus.lu_rd != '0);

   assign bus.lu_ready = ~w_full;
   assign bus.stall    = r_stall;

   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      w_count_next  = r_count + CW'(w_enq) - CW'(w_deq);
      w_starve_next = r_starve;
      if (w_count_next == '0 || w_deq)
         w_starve_next = '0;
      else if (!w_empty && r_starve < STARVE_LIM)
         w_starve_next = r_starve + SW'(1);
      w_stall_next = (w_count_next != '0) && (w_starve_next >= STARVE_LIM);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_starve <= '0;
         r_stall  <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
         if (w_enq) r_wptr <= r_wptr + PW'(1);
         if (w_deq) r_rptr <= r_rptr + PW'(1);
         r_count  <= w_count_next;
         r_starve <= w_starve_next;
         r_stall  <= w_stall_next;
      end
   end

   // NOTE: entry storage is not reset; r_count alone decides which slots hold live data.
   always_ff @(posedge clk) begin
      if (w_enq) r_mem[r_wptr] <= '{rd: bus.lu_rd, data: bus.lu_data};
   end

   always_comb begin
      bus.rf_we    = 1'b0;
      bus.rf_waddr = '0;
      bus.rf_wdata = '0;
      if (rst_n) begin
         if (w_wb_req) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = bus.wb_rd;
            bus.rf_wdata = bus.wb_memtoreg ? bus.wb_readdata : bus.wb_alu_result;
         end else if (!w_empty) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = r_mem[r_rptr].rd;
            bus.rf_wdata = r_mem[r_rptr].data;
         end
      end
   end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the MEM/WB writeback stage and a long-latency result source, such as a multi-cycle multiply/divide unit. Long-latency results are held in a small FIFO and written back only in cycles with no pipeline writeback. A starvation counter raises a one-cycle pipeline stall so a buffered result is never blocked indefinitely. The block sits between the MEM/WB pipeline register outputs and the register file write port.

## Interface
- XLEN, 64, data width
- REGW, 5, register index width
- DEPTH, 2, long-latency result FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, cycles a FIFO head may wait before stall is forced (≥1)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wb_regwrite  in  1  MEM/WB RegWrite
- wb_memtoreg  in  1  MEM/WB MemtoReg; 1 selects wb_readdata
- wb_readdata  in  XLEN  MEM/WB memory read data
- wb_alu_result  in  XLEN  MEM/WB ALU result
- wb_rd  in  REGW  MEM/WB destination register
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept a result
- lu_rd  in  REGW  long-latency destination register
- lu_data  in  XLEN  long-latency result
- rf_we  out  1  register file write enable
- rf_waddr  out  REGW  register file write address
- rf_wdata  out  XLEN  register file write data
- stall  out  1  freeze all pipeline stages, including MEM/WB, this cycle

## Operation
- Write request: wb_req = wb_regwrite & (wb_rd != 0) & ~stall.
- While stall=1, the pipeline holds MEM/WB, so the same instruction is re-presented the next cycle.
- Port select is combinational from the current state and inputs:
  - If wb_req: rf_we=1, rf_waddr=wb_rd, rf_wdata = wb_memtoreg ? wb_readdata : wb_alu_result.
  - Else if the FIFO is non-empty: write the head entry (rd, data) and dequeue it at the next edge.
  - Else: rf_we=0. rf_waddr and rf_wdata are don't-care; drive 0.
- Enqueue occurs when lu_valid & lu_ready.
  - Entries with lu_rd==0 are handshaken but discarded; they are not stored.
- lu_ready = ~full.
  - It depends only on registered occupancy; there is no combinational path from the dequeue decision.
  - When the FIFO is full, no enqueue occurs even if a dequeue happens the same cycle.
- FIFO rules:
  - No bypass: an entry enqueued at edge N is first eligible in the cycle after edge N.
  - Strict FIFO order.
  - Pointers wrap modulo DEPTH.
  - Occupancy counter is $clog2(DEPTH)+1 bits.
- Starvation counter starve_cnt:
  - Cleared when the FIFO is empty after the edge, or when a dequeue occurs.
  - Otherwise increments each cycle a non-empty FIFO is not dequeued.
  - Saturates at STARVE_MAX.
- stall is registered: stall_next = (FIFO non-empty after edge) & (starve_cnt_next ≥ STARVE_MAX).
  - In a stall cycle wb_req=0, so the head is always written; starve_cnt then clears and stall drops the following cycle.
  - Each stall therefore lasts exactly one cycle per drained entry.
- No address-conflict checking. Same-rd ordering between wb and buffered results is the hazard unit's responsibility; the later register-file write wins.

## Timing
- Reset (rst_n low, asynchronous):
  - FIFO empty, pointers 0, starve_cnt=0, stall=0, lu_ready=1.
  - rf_we forced 0 while rst_n=0.
- Reset mid-operation discards all buffered entries; no writes occur for them.
- Pipeline writeback has zero latency: rf_* follow wb_* in the same cycle.
- Long-latency writeback, best case: accepted at edge N, written in the cycle after edge N, dequeued at edge N+1.
- Worst-case wait for a head entry: STARVE_MAX blocked cycles plus 1 stall cycle.
- Example, STARVE_MAX=4, continuous wb_req:
  - Entry enqueued at edge 0.
  - starve_cnt reaches 4 at edge 4.
  - stall=1 in the cycle after edge 4, and the head is written that cycle.
  - Dequeue at edge 5; stall=0 after edge 5 if the FIFO is empty, otherwise a second entry begins its own count from 0.

## Test plan
- Reset: rst_n=0 with wb_regwrite=1 -> rf_we=0, stall=0, lu_ready=1. Release -> rf_we follows wb_regwrite.
- Pipeline-only traffic:
  - wb_rd=5, wb_memtoreg=1, readdata=0xAA, alu=0xBB -> rf_wdata=0xAA.
  - wb_memtoreg=0 -> rf_wdata=0xBB.
  - wb_rd=0 -> rf_we=0.
- Idle-slot drain: lu push (rd=7, 0x1234) with wb_regwrite=0 -> write of r7=0x1234 one cycle after acceptance; FIFO empty afterwards.
- Starvation: push 1 entry under continuous wb_req with STARVE_MAX=4 -> stall=1 for exactly one cycle, 5 cycles after acceptance, with rf_waddr=lu rd; wb write resumes the next cycle with the same instruction.
- Full FIFO:
  - Push 3 entries under continuous wb_req with DEPTH=2 -> lu_ready=0 after 2 are accepted.
  - Third entry is accepted only after the first drain.
  - All three are written in order, each preceded by its own stall.
- Async reset mid-operation: assert rst_n low between edges with 2 entries buffered -> lu_ready=1 and stall=0 immediately; no buffered write ever appears.
